usr_burst: RTL and testbench

USR_BURST -- requirements
Module: usr_burst

---
 rtl/usr_pkg.sv | 25 ++
 rtl/usr_slice.sv | 16 +
 rtl/usr_burst.sv | 91 +++++++++
 tb/tb_usr_burst.sv | 123 ++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// usr_pkg: mode codes, shift-class decode and FSM encoding shared by the usr_burst block
package usr_pkg;
    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_NOP  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    function automatic logic is_shift(input logic [2:0] m);
        return m inside {M_SHR, M_SHL, M_ROR, M_ROL, M_ASR};
    endfunction

    function automatic logic is_right(input logic [2:0] m);
        return m inside {M_SHR, M_ROR, M_ASR};
    endfunction

    function automatic logic is_left(input logic [2:0] m);
        return m inside {M_SHL, M_ROL};
    endfunction
endpackage

// File: rtl/usr_slice.sv
// usr_slice: next-value multiplexer for one register bit
module usr_slice
    import usr_pkg::*;
(
    input  logic [2:0] op,
    input  logic       cur,
    input  logic       rin,
    input  logic       lin,
    input  logic       par,
    output logic       nxt
);
    // right-moving modes take the left neighbour, left-moving the right one
    always_comb begin
        nxt = is_right(op) ? rin : is_left(op) ? lin : (op == M_LOAD) ? par : cur;
    end
endmodule

// File: rtl/usr_burst.sv
// usr_burst: universal shift register with single-step operations and counted shift bursts
module usr_burst
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt,
    input  logic             sisr,
    input  logic             sisl,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q,
    output logic             sor,
    output logic             sol,
    output logic             busy,
    output logic             done
);
    state_t           state, state_nxt;
    logic [CNT_W-1:0] rem, rem_nxt;
    logic [2:0]       mode_q, mode_nxt, op;
    logic [WIDTH-1:0] q_nxt, rin, lin;
    logic             accept, msb_in, lsb_in;

    // pick the operation for this edge and the serial values entering each end
    always_comb begin
        accept = (state == S_IDLE) && start && is_shift(mode);
        op     = (state == S_RUN) ? mode_q :
                 (state != S_IDLE) ? M_HOLD :
                 accept ? ((cnt != '0) ? mode : M_HOLD) :
                 en ? mode : M_HOLD;
        msb_in = (op == M_SHR) ? sisr : (op == M_ROR) ? q[0] : q[WIDTH-1];
        lsb_in = (op == M_SHL) ? sisl : q[WIDTH-1];
        rin    = {msb_in, q[WIDTH-1:1]};
        lin    = {q[WIDTH-2:0], lsb_in};
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        usr_slice u_slice (
            .op (op),
            .cur(q[i]),
            .rin(rin[i]),
            .lin(lin[i]),
            .par(pin[i]),
            .nxt(q_nxt[i])
        );
    end

    // burst sequencing: accept in IDLE, count shifts in RUN, one-cycle FIN
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        mode_nxt  = mode_q;
        case (state)
            S_IDLE: if (accept) begin
                mode_nxt  = mode;
                rem_nxt   = (cnt == '0) ? '0 : cnt - CNT_W'(1);
                state_nxt = (cnt > CNT_W'(1)) ? S_RUN : S_FIN;
            end
            S_RUN: begin
                rem_nxt   = rem - CNT_W'(1);
                state_nxt = (rem == CNT_W'(1)) ? S_FIN : S_RUN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // register and FSM state, clear has priority
    always_ff @(posedge clk) begin
        if (clear) begin
            q      <= '0;
            state  <= S_IDLE;
            rem    <= '0;
            mode_q <= M_HOLD;
        end else begin
            q      <= q_nxt;
            state  <= state_nxt;
            rem    <= rem_nxt;
            mode_q <= mode_nxt;
        end
    end

    assign sor  = q[0];
    assign sol  = q[WIDTH-1];
    assign busy = (state != S_IDLE);
    assign done = (state == S_FIN);
endmodule

// File: tb/tb_usr_burst.sv
// tb_usr_burst: scoreboard bench with directed vectors for usr_burst
module tb_usr_burst;
    logic       clk = 1'b0;
    logic       clear = 1'b0, en = 1'b0, start = 1'b0, sisr = 1'b0, sisl = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [3:0] cnt = 4'd0;
    logic [7:0] pin = 8'h00;
    logic [7:0] q;
    logic       sor, sol, busy, done;

    typedef struct packed {
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t  sb[$];
    string names[$];
    int    total = 0, bad = 0;

    usr_burst #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .clear(clear), .en(en), .mode(mode), .start(start), .cnt(cnt),
        .sisr(sisr), .sisl(sisl), .pin(pin), .q(q), .sor(sor), .sol(sol),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // one clock edge with the current inputs, then queue what the outputs must be
    task automatic step(input string nm, input logic [7:0] eq, input logic eb, input logic ed);
        @(posedge clk);
        #1;
        sb.push_back('{q: eq, busy: eb, done: ed});
        names.push_back(nm);
    endtask

    task automatic load(input logic [7:0] v);
        clear = 0; start = 0; en = 1; mode = 3'b011; pin = v;
        step("load", v, 0, 0);
    endtask

    // monitor: outputs settle after the edge, compare on the falling edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t  e;
            string nm;
            e  = sb.pop_front();
            nm = names.pop_front();
            total++;
            if (q !== e.q || busy !== e.busy || done !== e.done || sor !== e.q[0] || sol !== e.q[7]) begin
                bad++;
                $display("FAIL %s: got q=%h sor=%b sol=%b busy=%b done=%b, want q=%h sor=%b sol=%b busy=%b done=%b",
                         nm, q, sor, sol, busy, done, e.q, e.q[0], e.q[7], e.busy, e.done);
            end
        end
    end

    initial begin
        clear = 1;
        step("reset", 8'h00, 0, 0);
        load(8'hA5);
        mode = 3'b001; sisr = 1;
        step("shr", 8'hD2, 0, 0);
        load(8'h81); mode = 3'b100; step("ror", 8'hC0, 0, 0);
        load(8'h81); mode = 3'b101; step("rol", 8'h03, 0, 0);
        load(8'h81); mode = 3'b110; step("asr", 8'hC0, 0, 0);
        load(8'h81); mode = 3'b010; sisl = 0; step("shl", 8'h02, 0, 0);
        load(8'h81); en = 0; mode = 3'b001; step("en_off", 8'h81, 0, 0);
        load(8'h81); mode = 3'b111; step("mode7_hold", 8'h81, 0, 0);
        // burst of three left shifts, with junk inputs while busy
        load(8'h01);
        en = 0; mode = 3'b010; sisl = 0; cnt = 4'd3; start = 1;
        step("burst1", 8'h02, 1, 0);
        start = 0; en = 1; mode = 3'b011; pin = 8'hFF;
        step("burst2", 8'h04, 1, 0);
        step("burst3", 8'h08, 1, 1);
        en = 0;
        step("burst_end", 8'h08, 0, 0);
        // zero-length burst
        start = 1; en = 1; mode = 3'b001; cnt = 4'd0;
        step("zero_fin", 8'h08, 1, 1);
        start = 0; en = 0;
        step("zero_end", 8'h08, 0, 0);
        // live serial input during a right-shift burst
        load(8'h00);
        en = 0; mode = 3'b001; cnt = 4'd2; start = 1; sisr = 1;
        step("live1", 8'h80, 1, 0);
        start = 0; sisr = 0;
        step("live2", 8'h40, 1, 1);
        step("live_end", 8'h40, 0, 0);
        // abort by clear on the second busy cycle
        load(8'h01);
        en = 0; mode = 3'b010; sisl = 1; cnt = 4'd5; start = 1;
        step("abort1", 8'h03, 1, 0);
        start = 0; clear = 1;
        step("abort_clr", 8'h00, 0, 0);
        clear = 0;
        step("abort_nodone", 8'h00, 0, 0);
        // start pulsed mid-burst must not extend it
        load(8'h01);
        en = 0; mode = 3'b010; sisl = 0; cnt = 4'd3; start = 1;
        step("ign1", 8'h02, 1, 0);
        start = 1; cnt = 4'd7;
        step("ign2", 8'h04, 1, 0);
        start = 0;
        step("ign3", 8'h08, 1, 1);
        step("ign_end", 8'h08, 0, 0);
        // start with non-shift modes acts as a direct operation
        start = 1; en = 1; mode = 3'b011; pin = 8'h5A;
        step("start_load", 8'h5A, 0, 0);
        mode = 3'b000;
        step("start_hold", 8'h5A, 0, 0);
        start = 0; en = 0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
